// File: rtl/score_argmax.sv
// score_argmax: per-image argmax over NUM_CLASSES signed scores; tie rule set by ARGMAX_TIE_LAST_EN
module score_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int NUM_IMAGES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [SCORE_W-1:0] in_score,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_class,
    output logic [SCORE_W-1:0] out_score,
    output logic [3:0]         out_image,
    output logic               batch_done
);
`ifdef ARGMAX_TIE_LAST_EN
    localparam bit TIE_LAST = 1'b1;
`else
    localparam bit TIE_LAST = 1'b0;
`endif
    logic [3:0]         cls_q, cls_d, arg_q, arg_d, out_class_q, out_class_d, out_image_q, out_image_d;
    logic [SCORE_W-1:0] max_q, max_d, out_score_q, out_score_d;
    logic               out_valid_q, out_valid_d;
    logic               acc, hs, last, take, done;
    logic [3:0]         new_arg;
    logic [SCORE_W-1:0] new_max;
    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_score  = out_score_q;
    assign out_image  = out_image_q;
    assign batch_done = hs && !flush && out_image_q == 4'(NUM_IMAGES - 1);
    // next-state: running argmax over the group and the held result slot
    always_comb begin
        acc         = in_valid && in_ready;
        hs          = out_valid_q && out_ready;
        last        = cls_q == 4'(NUM_CLASSES - 1);
        take        = cls_q == 4'd0 || (TIE_LAST ? $signed(in_score) >= $signed(max_q)
                                                 : $signed(in_score) > $signed(max_q));
        new_max     = take ? in_score : max_q;
        new_arg     = take ? cls_q : arg_q;
        done        = acc && last && !flush;
        max_d       = acc ? new_max : max_q;
        arg_d       = acc ? new_arg : arg_q;
        cls_d       = flush ? 4'd0 : acc ? (last ? 4'd0 : cls_q + 4'd1) : cls_q;
        out_valid_d = flush ? 1'b0 : done ? 1'b1 : hs ? 1'b0 : out_valid_q;
        out_class_d = done ? new_arg : out_class_q;
        out_score_d = done ? new_max : out_score_q;
        out_image_d = flush ? 4'd0 : hs ? (out_image_q == 4'(NUM_IMAGES - 1) ? 4'd0 : out_image_q + 4'd1) : out_image_q;
    end
    // state registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q       <= '0;
            arg_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
            out_image_q <= '0;
        end else begin
            cls_q       <= cls_d;
            arg_q       <= arg_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
            out_image_q <= out_image_d;
        end
    end
endmodule

// File: tb/tb_score_argmax.sv
// tb_score_argmax: self-checking bench for score_argmax against a queue-based argmax model
module tb_score_argmax;
`ifdef ARGMAX_TIE_LAST_EN
    localparam bit TIE_LAST = 1'b1;
`else
    localparam bit TIE_LAST = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_score = '0;
    logic        in_ready, out_valid, batch_done;
    logic [15:0] out_score;
    logic [3:0]  out_class, out_image;
    int tests = 0, errs = 0, bd_cnt = 0, bd0 = 0;
    int grp[$];
    bit ev = 1'b0;
    int ec = 0, es = 0, ei = 0;
    always #5 clk = ~clk;
    score_argmax dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_score(in_score),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_score(out_score), .out_image(out_image), .batch_done(batch_done)
    );
    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic void finish_group();
        int m = grp[0];
        foreach (grp[i]) if (grp[i] > m) m = grp[i];
        ec = -1;
        foreach (grp[i]) if (grp[i] == m && (TIE_LAST || ec < 0)) ec = i;
        es = m;
    endfunction
    function automatic int rnd_score();
        logic [15:0] t = 16'($urandom);
        return $urandom_range(0, 1) ? int'($signed(t)) : int'($urandom_range(0, 4)) - 2;
    endfunction
    task automatic check_outputs(input bit r, input bit f);
        chk("out_valid", int'(out_valid), int'(ev));
        chk("out_class", int'(out_class), ec);
        chk("out_score", int'($signed(out_score)), es);
        chk("out_image", int'(out_image), ei);
        chk("in_ready", int'(in_ready), int'(!ev || r));
        chk("batch_done", int'(batch_done), int'(ev && r && !f && ei == 9));
    endtask
    task automatic step(input bit v, input int s, input bit r, input bit f = 1'b0);
        bit acc, hs;
        @(negedge clk);
        in_valid = v; in_score = 16'(s); out_ready = r; flush = f;
        #1;
        check_outputs(r, f);
        if (batch_done) bd_cnt++;
        acc = v && (!ev || r);
        hs = ev && r;
        if (f) begin
            grp.delete(); ev = 1'b0; ei = 0;
        end else begin
            if (hs) begin ev = 1'b0; ei = (ei + 1) % 10; end
            if (acc) begin
                grp.push_back(s);
                if (grp.size() == 10) begin finish_group(); ev = 1'b1; grp.delete(); end
            end
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        grp.delete(); ev = 1'b0; ec = 0; es = 0; ei = 0;
        check_outputs(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask
    initial begin
        int g1[10] = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 2};
        do_reset();
        foreach (g1[i]) step(1'b1, g1[i], 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req34_valid", int'(out_valid), 1);
        chk("req34_class", int'(out_class), 2);
        chk("req34_score", int'($signed(out_score)), 100);
        chk("req34_image", int'(out_image), 0);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, -32768, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req35_class", int'(out_class), TIE_LAST ? 9 : 0);
        chk("req35_score", int'($signed(out_score)), -32768);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, i == 0 ? -32768 : i == 1 ? 32767 : 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req36_class", int'(out_class), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 999, 1'b0);
        chk("req37_held_class", int'(out_class), 1);
        chk("req37_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 10; i++) step(1'b1, i == 4 ? 20000 : i * 10, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req37_next_class", int'(out_class), 4);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 30000, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, i == 3 ? 500 : -i, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("flush_class", int'(out_class), 3);
        chk("flush_image", int'(out_image), 0);
        do_reset();
        bd0 = bd_cnt;
        for (int g = 0; g < 100; g++) step(1'b1, rnd_score(), 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("req38_pulses", bd_cnt - bd0, 1);
        for (int i = 0; i < 10; i++) step(1'b1, rnd_score(), 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req38_wrap_image", int'(out_image), 0);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 30000, 1'b1);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, i == 6 ? 5000 : int'($urandom_range(0, 2000)) - 1000, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("req39_class", int'(out_class), 6);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, rnd_score(), $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/score_argmax.md
SCORE_ARGMAX -- requirements
Module: score_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: scores per image.
REQ-002 SHALL have parameter SCORE_W, default 16: signed two's-complement score width, matching the layer-2 rdata width.
REQ-003 SHALL have parameter NUM_IMAGES, default 10: images per batch, matching the 10-image parallel pixel bus.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous clear of group and batch progress.
REQ-007 SHALL have port in_valid, input, 1: score beat present.
REQ-008 SHALL have port in_score, input, SCORE_W: layer-2 output score, signed.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-010 SHALL have port out_valid, output, 1: classification result held.
REQ-011 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-012 SHALL have port out_class, output, 4: winning class index, 0..NUM_CLASSES-1.
REQ-013 SHALL have port out_score, output, SCORE_W: winning score.
REQ-014 SHALL have port out_image, output, 4: image index within the batch, 0..NUM_IMAGES-1.
REQ-015 SHALL have port batch_done, output, 1: one-cycle pulse when the result for image NUM_IMAGES-1 is consumed.

Function
REQ-016 SHALL treat accepted beats as consecutive groups of NUM_CLASSES; the k-th beat of a group (k=0..NUM_CLASSES-1) is class k.
REQ-017 SHALL track the class number with a counter that increments per accepted beat and wraps from NUM_CLASSES-1 to 0.
REQ-018 SHALL load the running max and argmax unconditionally on beat k=0.
REQ-019 SHALL, on beats k>0, compare in_score against the running max using a signed comparison, with the tie rule given in Configuration.
REQ-020 SHALL, on acceptance of beat k=NUM_CLASSES-1, register the final argmax and max (this beat included) into out_class and out_score, and assert out_valid the next cycle.
REQ-021 SHALL give a latency of exactly 1 cycle from the last-beat handshake to out_valid high.
REQ-022 SHALL hold out_valid, out_class, out_score and out_image stable until the out_valid && out_ready handshake.
REQ-023 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-024 SHALL, when a last-beat acceptance and an output handshake coincide, load the new result and keep out_valid high with no bubble.
REQ-025 SHALL increment out_image on each output handshake, wrapping from NUM_IMAGES-1 to 0.
REQ-026 SHALL pulse batch_done on the handshake where out_image was NUM_IMAGES-1.
REQ-027 SHALL, on flush, clear the class counter, out_valid and out_image; flush takes priority over simultaneous handshakes.
REQ-028 SHALL ignore in_score whenever in_valid is low.

Reset
REQ-029 SHALL, on reset, immediately clear: out_valid=0, out_class=0, out_score=0, out_image=0, batch_done=0, class counter=0, running max=0, argmax=0.
REQ-030 SHALL discard any partial group when reset asserts mid-group; the next accepted beat after reset is class 0.

Configuration
REQ-031 SHALL recognise macro ARGMAX_TIE_LAST_EN.
REQ-032 SHALL, with ARGMAX_TIE_LAST_EN defined, replace the max when in_score >= max, so the highest index wins ties.
REQ-033 SHALL, without ARGMAX_TIE_LAST_EN, replace the max only when in_score > max, so the lowest index wins ties.

Verification
REQ-034 Scores 5,-3,100,7,0,0,0,0,0,2 with out_ready=1 -> out_valid 1 cycle after the last beat; out_class=2, out_score=100, out_image=0.
REQ-035 All ten scores = -32768 -> out_class=0 without the macro and out_class=9 with it; out_score=-32768 in both cases.
REQ-036 Scores 0x8000 and 0x7FFF at classes 0 and 1, all others 0 -> out_class=1 (signed comparison confirmed).
REQ-037 out_ready=0 after result 0 is held -> in_ready=0, the result stays stable and further beats are not accepted; out_ready=1 -> result 0 consumed and result 1 is produced with the correct class.
REQ-038 Ten back-to-back groups with out_ready=1 -> out_image runs 0..9, batch_done pulses once on image 9, and the next result has out_image=0.
REQ-039 reset pulsed after 4 beats, then 10 beats with max at class 6 -> out_class=6 and no spurious out_valid.
